formacao_inimigos: RTL and testbench

Parametrised enemy-formation controller for the invaders game: owns a LINHAS×COLUNAS grid of enemies that march as one body, bounce off the screen edges using the bounding box of the *surviving* columns, and descend on each bounce. It also detects projectile hits with per-enemy kill tracking and speeds up as enemies die. It sits between the player-projectile logic and the VGA sprite renderer. It replaces per-enemy instances with a single block on one clock domain, so there are no derived clocks.

---
 rtl/jogo_pkg.sv | 15 +
 rtl/divisor_passo.sv | 29 ++
 rtl/formacao_inimigos.sv | 207 ++++++++++++++++++++
 tb/tb_formacao_inimigos.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared game constants and types.
// Screen size, default sprite size and march direction.
package jogo_pkg;

  localparam int TELA_L = 640;
  localparam int TELA_A = 480;
  localparam int LARG   = 33;
  localparam int ALT    = 24;

  typedef enum logic {
    DIR_ESQ = 1'b0,
    DIR_DIR = 1'b1
  } dir_e;

endpackage

// File: rtl/divisor_passo.sv
// Programmable tick generator for the formation march.
// Emits a one-cycle tick every periodo_i enabled cycles.
module divisor_passo (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] periodo_i,
  output logic        tick_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // fire at or past the last count so a shrinking period never overruns
  always_comb begin
    tick_o = en_i && (cnt_q >= periodo_i - 32'd1);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = tick_o ? 32'd0 : cnt_q + 32'd1;
    end
  end

  // cycle counter, held while disabled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/formacao_inimigos.sv
// Enemy formation: march, bounce, descend, hits and speed-up.
// One clock domain; all geometry sums kept at 11 bits.
module formacao_inimigos
  import jogo_pkg::*;
#(
  parameter int LINHAS    = 3,
  parameter int COLUNAS   = 8,
  parameter int LARG      = jogo_pkg::LARG,
  parameter int ALT       = jogo_pkg::ALT,
  parameter int ESP_X     = 48,
  parameter int ESP_Y     = 36,
  parameter int TELA_L    = jogo_pkg::TELA_L,
  parameter int Y_LIMITE  = 440,
  parameter int PASSO_X   = 2,
  parameter int DESCIDA   = 20,
  parameter int DIV_MIN   = 40000,
  parameter int DIV_PASSO = 11667,
  localparam int N  = LINHAS * COLUNAS,
  localparam int IW = $clog2(N),
  localparam int RW = $clog2(N + 1)
) (
  input  logic          CLOCK_50,
  input  logic          resetInimigo,
  input  logic          pausa,
  input  logic [9:0]    x0,
  input  logic [9:0]    y0,
  input  logic          bola_valida,
  input  logic [9:0]    x_bola,
  input  logic [9:0]    y_bola,
  output logic [9:0]    ox,
  output logic [9:0]    oy,
  output logic [N-1:0]  vivos,
  output logic          acerto,
  output logic [IW-1:0] indice_acerto,
  output logic [RW-1:0] restantes,
  output logic          zerado,
  output logic          invadiu
);

  logic [9:0]    ox_q, ox_d, oy_q, oy_d;
  logic [N-1:0]  vivos_q, vivos_d;
  logic          acerto_q, acerto_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] rest_q, rest_d;
  logic          zerado_q, zerado_d;
  logic          invadiu_q, invadiu_d;
  logic          trava_q, trava_d;
  dir_e          dir_q, dir_d;

  logic          tick;
  logic [31:0]   periodo;
  logic [N-1:0]  hit_v;
  logic [N-1:0]  k_oh;
  logic          kill;
  logic [IW-1:0] kidx;
  logic [COLUNAS-1:0] col_v;
  logic [LINHAS-1:0]  lin_v;
  logic [10:0]   xmin_off, xmax_off, ymax_off;
  logic [10:0]   xb, yb;
  logic [10:0]   borda_d, borda_e, oy_s, fundo;
  logic          desce;

  assign xb = {1'b0, x_bola};
  assign yb = {1'b0, y_bola};

  assign periodo = 32'(DIV_MIN) + 32'(rest_q) * 32'(DIV_PASSO);

  divisor_passo u_div (
    .clk_i     (CLOCK_50),
    .rst_i     (resetInimigo),
    .en_i      (!pausa),
    .periodo_i (periodo),
    .tick_o    (tick)
  );

  for (genvar r = 0; r < LINHAS; r++) begin : g_lin
    for (genvar c = 0; c < COLUNAS; c++) begin : g_cel
      logic [10:0] cx, cy;
      assign cx = {1'b0, ox_q} + 11'(c * ESP_X);
      assign cy = {1'b0, oy_q} + 11'(r * ESP_Y);
      assign hit_v[r*COLUNAS+c] = bola_valida
        && vivos_q[r*COLUNAS+c]
        && (cx < xb) && (xb < cx + 11'(LARG))
        && (cy < yb) && (yb < cy + 11'(ALT));
    end
    assign lin_v[r] = |vivos_q[r*COLUNAS +: COLUNAS];
  end

  for (genvar c = 0; c < COLUNAS; c++) begin : g_col
    logic [LINHAS-1:0] bits;
    for (genvar r = 0; r < LINHAS; r++) begin : g_b
      assign bits[r] = vivos_q[r*COLUNAS+c];
    end
    assign col_v[c] = |bits;
  end

  // lowest index wins; one kill per projectile
  always_comb begin
    kill = 1'b0;
    kidx = '0;
    k_oh = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        kill    = 1'b1;
        kidx    = IW'(i);
        k_oh    = '0;
        k_oh[i] = 1'b1;
      end
    end
    if (trava_q) begin
      kill = 1'b0;
      k_oh = '0;
    end
  end

  // pixel offsets of the surviving bounding box
  always_comb begin
    xmin_off = '0;
    xmax_off = '0;
    ymax_off = '0;
    for (int c = COLUNAS - 1; c >= 0; c--) begin
      if (col_v[c]) xmin_off = 11'(c * ESP_X);
    end
    for (int c = 0; c < COLUNAS; c++) begin
      if (col_v[c]) xmax_off = 11'(c * ESP_X);
    end
    for (int r = 0; r < LINHAS; r++) begin
      if (lin_v[r]) ymax_off = 11'(r * ESP_Y);
    end
  end

  // next state: kills, march, bounce, invasion
  always_comb begin
    ox_d      = ox_q;
    oy_d      = oy_q;
    dir_d     = dir_q;
    invadiu_d = invadiu_q;
    vivos_d   = vivos_q & ~k_oh;
    acerto_d  = kill;
    idx_d     = kill ? kidx : idx_q;
    rest_d    = kill ? rest_q - RW'(1) : rest_q;
    zerado_d  = zerado_q | (rest_d == '0);
    trava_d   = trava_q;
    if (!bola_valida) trava_d = 1'b0;
    else if (kill)    trava_d = 1'b1;
    desce   = 1'b0;
    borda_d = {1'b0, ox_q} + xmax_off + 11'(LARG) + 11'(PASSO_X);
    borda_e = {1'b0, ox_q} + xmin_off;
    oy_s    = {1'b0, oy_q} + 11'(DESCIDA);
    fundo   = oy_s + ymax_off + 11'(ALT);
    if (tick && !zerado_q && !invadiu_q) begin
      unique case (dir_q)
        DIR_DIR: begin
          if (borda_d > 11'(TELA_L)) desce = 1'b1;
          else ox_d = ox_q + 10'(PASSO_X);
        end
        DIR_ESQ: begin
          if (borda_e < 11'(PASSO_X)) desce = 1'b1;
          else ox_d = ox_q - 10'(PASSO_X);
        end
        default: ;
      endcase
      if (desce) begin
        oy_d  = oy_s[9:0];
        dir_d = (dir_q == DIR_DIR) ? DIR_ESQ : DIR_DIR;
        if (fundo >= 11'(Y_LIMITE)) invadiu_d = 1'b1;
      end
    end
  end

  // state registers; origin loaded from x0/y0 while in reset
  always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
    if (resetInimigo) begin
      ox_q      <= x0;
      oy_q      <= y0;
      vivos_q   <= '1;
      acerto_q  <= 1'b0;
      idx_q     <= '0;
      rest_q    <= RW'(N);
      zerado_q  <= 1'b0;
      invadiu_q <= 1'b0;
      trava_q   <= 1'b0;
      dir_q     <= DIR_DIR;
    end else begin
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      vivos_q   <= vivos_d;
      acerto_q  <= acerto_d;
      idx_q     <= idx_d;
      rest_q    <= rest_d;
      zerado_q  <= zerado_d;
      invadiu_q <= invadiu_d;
      trava_q   <= trava_d;
      dir_q     <= dir_d;
    end
  end

  assign ox            = ox_q;
  assign oy            = oy_q;
  assign vivos         = vivos_q;
  assign acerto        = acerto_q;
  assign indice_acerto = idx_q;
  assign restantes     = rest_q;
  assign zerado        = zerado_q;
  assign invadiu       = invadiu_q;

endmodule

// File: tb/tb_formacao_inimigos.sv
// Bench for formacao_inimigos: march, hits, bounds, speed.
// Kill indices go through a scoreboard queue.
module tb_formacao_inimigos;
  import jogo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pausa = 1'b0;
  logic [9:0] x0 = 10'd100;
  logic [9:0] y0 = 10'd50;
  logic       bv = 1'b0;
  logic [9:0] xb = '0;
  logic [9:0] yb = '0;

  logic [9:0]  ox, oy, ox_e, oy_e, ox_v, oy_v;
  logic [23:0] viv, viv_e, viv_v;
  logic        ac, ac_e, ac_v, zr, zr_e, zr_v, inv, inv_e, inv_v;
  logic [4:0]  idx, idx_e, idx_v, rs, rs_e, rs_v;

  int n_ok = 0;
  int n_tot = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  formacao_inimigos #(.DIV_MIN(2), .DIV_PASSO(0)) u_dut (
    .CLOCK_50(clk), .resetInimigo(rst), .pausa(pausa),
    .x0(x0), .y0(y0), .bola_valida(bv), .x_bola(xb), .y_bola(yb),
    .ox(ox), .oy(oy), .vivos(viv), .acerto(ac),
    .indice_acerto(idx), .restantes(rs), .zerado(zr), .invadiu(inv));

  formacao_inimigos #(.ESP_X(20), .DIV_MIN(2), .DIV_PASSO(0)) u_esp (
    .CLOCK_50(clk), .resetInimigo(rst), .pausa(pausa),
    .x0(x0), .y0(y0), .bola_valida(bv), .x_bola(xb), .y_bola(yb),
    .ox(ox_e), .oy(oy_e), .vivos(viv_e), .acerto(ac_e),
    .indice_acerto(idx_e), .restantes(rs_e), .zerado(zr_e), .invadiu(inv_e));

  formacao_inimigos #(.DIV_MIN(2), .DIV_PASSO(1)) u_vel (
    .CLOCK_50(clk), .resetInimigo(rst), .pausa(pausa),
    .x0(x0), .y0(y0), .bola_valida(bv), .x_bola(xb), .y_bola(yb),
    .ox(ox_v), .oy(oy_v), .vivos(viv_v), .acerto(ac_v),
    .indice_acerto(idx_v), .restantes(rs_v), .zerado(zr_v), .invadiu(inv_v));

  // scoreboard: every kill pulse on the main DUT pops one expected index
  always @(negedge clk) begin
    if (ac === 1'b1) begin
      n_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: kill idx %0d, none expected", idx);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (idx !== 5'(e))
          $display("FAIL sb_idx: got %0d want %0d", idx, e);
        else n_ok++;
      end
    end
  end

  task automatic wcyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int x, input int y);
    @(negedge clk);
    bv = 1'b0;
    rst = 1'b1;
    x0 = 10'(x);
    y0 = 10'(y);
    wcyc(2);
    rst = 1'b0;
  endtask

  task automatic ball(input int x, input int y);
    xb = 10'(x);
    yb = 10'(y);
    bv = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(100, 50);
    n_tot++;
    if ({ox, oy} !== {10'd100, 10'd50})
      $display("FAIL rst_pos: got %0d,%0d want 100,50", ox, oy);
    else n_ok++;
    n_tot++;
    if (viv !== 24'hFFFFFF || rs !== 5'd24)
      $display("FAIL rst_vivos: got %h/%0d want ffffff/24", viv, rs);
    else n_ok++;
    n_tot++;
    if ({ac, idx, zr, inv} !== 8'd0)
      $display("FAIL rst_flags: got %b%0d%b%b want 0", ac, idx, zr, inv);
    else n_ok++;
  endtask

  task automatic test_first_bounce;
    do_reset(100, 50);
    wcyc(170);
    n_tot++;
    if ({ox, oy} !== {10'd270, 10'd50})
      $display("FAIL t85: got %0d,%0d want 270,50", ox, oy);
    else n_ok++;
    wcyc(2);
    n_tot++;
    if ({ox, oy} !== {10'd270, 10'd70} || u_dut.dir_q !== DIR_ESQ)
      $display("FAIL t86: got %0d,%0d want 270,70 left", ox, oy);
    else n_ok++;
    wcyc(2);
    n_tot++;
    if (ox !== 10'd268)
      $display("FAIL t87: got %0d want 268", ox);
    else n_ok++;
  endtask

  task automatic test_single_hit;
    do_reset(100, 50);
    ball(110, 60);
    exp_q.push_back(0);
    wcyc(1);
    n_tot++;
    if (viv[0] !== 1'b0 || ac !== 1'b1 || idx !== 5'd0 || rs !== 5'd23)
      $display("FAIL hit: got v0=%b ac=%b idx=%0d r=%0d want 0 1 0 23",
               viv[0], ac, idx, rs);
    else n_ok++;
    wcyc(1);
    n_tot++;
    if (ac !== 1'b0)
      $display("FAIL hit_pulse: got %b want 0", ac);
    else n_ok++;
    wcyc(6);
    bv = 1'b0;
    wcyc(2);
    n_tot++;
    if (rs !== 5'd23 || viv !== 24'hFFFFFE)
      $display("FAIL hit_hold: got %0d/%h want 23/fffffe", rs, viv);
    else n_ok++;
  endtask

  task automatic test_boundary;
    int bx[3] = '{100, 133, 110};
    int by[3] = '{60, 60, 50};
    for (int k = 0; k < 3; k++) begin
      do_reset(100, 50);
      ball(bx[k], by[k]);
      wcyc(1);
      n_tot++;
      if (rs !== 5'd24 || ac !== 1'b0)
        $display("FAIL edge_%0d: got r=%0d ac=%b want 24 0", k, rs, ac);
      else n_ok++;
      bv = 1'b0;
    end
  endtask

  task automatic test_priority;
    do_reset(100, 50);
    ball(125, 60);
    exp_q.push_back(0);
    wcyc(1);
    bv = 1'b0;
    n_tot++;
    if (viv_e[1:0] !== 2'b10 || idx_e !== 5'd0 || rs_e !== 5'd23)
      $display("FAIL prio: got %b idx=%0d r=%0d want 10 0 23",
               viv_e[1:0], idx_e, rs_e);
    else n_ok++;
  endtask

  task automatic test_column_shrink;
    do_reset(100, 50);
    ball(446, 60);  exp_q.push_back(7);  wcyc(1); bv = 1'b0; wcyc(1);
    ball(446, 96);  exp_q.push_back(15); wcyc(1); bv = 1'b0; wcyc(1);
    ball(446, 132); exp_q.push_back(23); wcyc(1); bv = 1'b0;
    wcyc(213);
    n_tot++;
    if ({ox, oy} !== {10'd318, 10'd50} || rs !== 5'd21)
      $display("FAIL shrink_109: got %0d,%0d r=%0d want 318,50 21", ox, oy, rs);
    else n_ok++;
    wcyc(2);
    n_tot++;
    if ({ox, oy} !== {10'd318, 10'd70})
      $display("FAIL shrink_110: got %0d,%0d want 318,70", ox, oy);
    else n_ok++;
  endtask

  task automatic test_invasion;
    do_reset(100, 400);
    wcyc(170);
    n_tot++;
    if (inv !== 1'b0 || oy !== 10'd400)
      $display("FAIL inv_pre: got %b,%0d want 0,400", inv, oy);
    else n_ok++;
    wcyc(2);
    n_tot++;
    if (inv !== 1'b1 || oy !== 10'd420)
      $display("FAIL inv_set: got %b,%0d want 1,420", inv, oy);
    else n_ok++;
    wcyc(10);
    n_tot++;
    if ({ox, oy} !== {10'd270, 10'd420})
      $display("FAIL inv_freeze: got %0d,%0d want 270,420", ox, oy);
    else n_ok++;
  endtask

  task automatic test_zerado;
    do_reset(100, 50);
    for (int i = 0; i < 24; i++) begin
      ball(100 + 2 * i + (i % 8) * 48 + 16, 50 + (i / 8) * 36 + 12);
      exp_q.push_back(i);
      wcyc(1);
      bv = 1'b0;
      wcyc(1);
    end
    wcyc(1);
    n_tot++;
    if (rs !== 5'd0 || zr !== 1'b1 || viv !== 24'd0)
      $display("FAIL zerado: got r=%0d z=%b v=%h want 0 1 0", rs, zr, viv);
    else n_ok++;
    wcyc(10);
    n_tot++;
    if (ox !== 10'd146)
      $display("FAIL zero_freeze: got %0d want 146", ox);
    else n_ok++;
  endtask

  task automatic test_reset_mid;
    do_reset(100, 50);
    ball(110, 60);
    exp_q.push_back(0);
    wcyc(1);
    bv = 1'b0;
    wcyc(30);
    #2 rst = 1'b1;
    #1;
    n_tot++;
    if ({ox, oy} !== {10'd100, 10'd50} || viv !== 24'hFFFFFF || rs !== 5'd24)
      $display("FAIL mid_rst: got %0d,%0d %h r=%0d want 100,50 ffffff 24",
               ox, oy, viv, rs);
    else n_ok++;
    @(negedge clk);
    rst = 1'b0;
    wcyc(1);
    n_tot++;
    if (ox !== 10'd100)
      $display("FAIL mid_t0: got %0d want 100", ox);
    else n_ok++;
    wcyc(1);
    n_tot++;
    if (ox !== 10'd102)
      $display("FAIL mid_t1: got %0d want 102", ox);
    else n_ok++;
  endtask

  task automatic test_speed;
    logic [9:0] p;
    int n;
    do_reset(100, 50);
    for (int k = 0; k < 2; k++) begin
      p = ox_v;
      n = 0;
      while (ox_v === p && n < 200) begin wcyc(1); n++; end
      n_tot++;
      if (n != 26) $display("FAIL per26_%0d: got %0d want 26", k, n);
      else n_ok++;
    end
    ball(112, 60);
    wcyc(1);
    bv = 1'b0;
    n_tot++;
    if (rs_v !== 5'd23)
      $display("FAIL vel_kill: got %0d want 23", rs_v);
    else n_ok++;
    p = ox_v;
    n = 0;
    while (ox_v === p && n < 200) begin wcyc(1); n++; end
    p = ox_v;
    n = 0;
    while (ox_v === p && n < 200) begin wcyc(1); n++; end
    n_tot++;
    if (n != 25) $display("FAIL per25: got %0d want 25", n);
    else n_ok++;
  endtask

  initial begin
    test_reset();
    test_first_bounce();
    test_single_hit();
    test_boundary();
    test_priority();
    test_column_shrink();
    test_invasion();
    test_zerado();
    test_reset_mid();
    test_speed();
    wcyc(2);
    n_tot++;
    if (exp_q.size() != 0)
      $display("FAIL sb_left: got %0d pending want 0", exp_q.size());
    else n_ok++;
    $display("%0d/%0d checks passed", n_ok, n_tot);
    $finish;
  end

endmodule
